instruction_loader: RTL and testbench
=====================================

Name: instruction_loader

Overview:
- Writer side of the instruction memory. Receives a program image as a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes each word into the instruction memory write port at word-aligned byte addresses. These addresses use the same PC/4 indexing as the fetch side.
- Holds the core while loading, then validates an XOR checksum and reports done or error.

Parameters:
- DEPTH, 32, number of 32-bit instruction words in the memory.
- COUNT_W, 6, width of word counters; must satisfy 2^COUNT_W > DEPTH.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR.
- in_valid  input  1  in_data holds a valid byte.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte; a transfer occurs when in_valid && in_ready at a clock edge.
- mem_write  output  1  one-cycle write strobe to the instruction memory.
- mem_address  output  32  byte address of the write, always a multiple of 4.
- mem_data  output  32  instruction word to write.
- core_hold  output  1  keeps the datapath PC in reset while loading.
- busy  output  1  a load is in progress.
- done  output  1  last load completed with a good checksum; level signal.
- error  output  1  last load failed; level signal.
- error_code  output  2  01 = bad word count, 10 = checksum mismatch, 00 = none.
- words_loaded  output  COUNT_W  number of words written in the current or last load.

Behaviour:
- Reset (async, active-high): state to IDLE.
  - Outputs to 0: in_ready, mem_write, mem_address, mem_data, core_hold, busy, done, error, error_code, words_loaded.
  - Internal accumulators and checksum cleared.
  - Memory contents are not touched.
- States and transitions:
  - IDLE: in_ready=0. On start go to COUNT; clear done, error, error_code, words_loaded and the checksum; set busy=1 and core_hold=1.
  - COUNT: in_ready=1. On the accepted byte N, XOR N into the checksum and latch it.
    - If N==0 or N>DEPTH: go to ERROR with error_code=01.
    - Otherwise go to DATA with byte index 0.
  - DATA: in_ready=1. Each accepted byte is XORed into the checksum and placed at bits [8*k+7:8*k], k = byte index 0..3.
    - When the 4th byte is accepted, go to WRITE.
  - WRITE: in_ready=0. For exactly one cycle: mem_write=1, mem_address=words_loaded*4, mem_data=assembled word.
    - words_loaded increments at the end of this cycle.
    - If words_loaded+1 == N, go to CHECK; otherwise return to DATA.
  - CHECK: in_ready=1. On the accepted byte:
    - If it equals the running checksum: go to DONE, done=1.
    - Otherwise: go to ERROR, error_code=10, error=1.
  - DONE / ERROR: busy=0, core_hold=0, in_ready=0. A start pulse restarts as in IDLE.
- Latency: mem_write is asserted in the cycle immediately after the 4th byte of a word is accepted.
- Backpressure: in_valid may drop at any time. Bytes are accepted only on in_valid && in_ready, and the FSM holds state while in_valid=0. There is no timeout.
- Outside WRITE: mem_write=0. mem_address and mem_data hold their last values.
- start while busy (COUNT/DATA/WRITE/CHECK) is ignored.
- A bad count reaches ERROR without any write. A checksum failure leaves the written words in memory; error signals that the image is invalid.
- Reset mid-load aborts immediately; partially written memory is left as-is.
- mem_address never exceeds (DEPTH-1)*4.

Test Plan:
- Normal 2-word load: start, then bytes 02, 93 00 50 00, 13 01 A0 00, 73.
  - Required: two one-cycle writes, (addr 0x0, data 0x00500093) then (addr 0x4, data 0x00A00113).
  - Then done=1, error=0, words_loaded=2, core_hold falls.
- Bad count: start, then byte 0x21 (33) -> ERROR, error_code=01, no mem_write, in_ready=0. Repeat with 0x00 -> same.
- Checksum mismatch: same image as the normal load but final byte 0x74 -> both words written, then error=1, error_code=10, done=0.
- Backpressure: normal image with in_valid low for 3 cycles between every byte -> identical writes and result; mem_write pulses exactly twice.
- Reset mid-load: assert reset after the 2nd data byte.
  - Required: all outputs are 0 within the same cycle, FSM is in IDLE, and a following full load completes correctly.
- Start handling: start pulse during DATA -> ignored, stream continues. Start after DONE -> new load begins with words_loaded=0 and done cleared.

Source files
------------

// File: rtl/instruction_loader_if.sv
// Byte-stream input and instruction-memory write port of the instruction loader.
// The master modport is the loader; slave is the stream source / memory side.
interface instruction_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_data;

    modport master (
        input  in_valid,
        input  in_data,
        output in_ready,
        output mem_write,
        output mem_address,
        output mem_data
    );

    modport slave (
        output in_valid,
        output in_data,
        input  in_ready,
        input  mem_write,
        input  mem_address,
        input  mem_data
    );
endinterface

// File: rtl/instruction_loader.sv
// Loads a byte-streamed program image into instruction memory as little-endian words,
// holding the core meanwhile and validating a trailing XOR checksum.
module instruction_loader #(
    parameter int unsigned DEPTH   = 32,
    parameter int unsigned COUNT_W = 6
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    instruction_loader_if.master bus,
    output logic                 core_hold,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [1:0]           error_code,
    output logic [COUNT_W-1:0]   words_loaded
);

    typedef enum logic [2:0] {
        StIdle, StCount, StData, StWrite, StCheck, StDone, StError
    } state_e;

    state_e               state_q, state_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic [COUNT_W-1:0]   words_q, words_d;
    logic [1:0]           byte_idx_q, byte_idx_d;
    logic [31:0]          word_q, word_d;
    logic [7:0]           csum_q, csum_d;
    logic [31:0]          mem_address_q, mem_address_d;
    logic [31:0]          mem_data_q, mem_data_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;
    logic [1:0]           error_code_q, error_code_d;
    logic                 in_ready_w;
    logic                 accept;

    assign in_ready_w = (state_q == StCount) || (state_q == StData) || (state_q == StCheck);
    assign accept     = bus.in_valid && in_ready_w;

    assign bus.in_ready    = in_ready_w;
    assign bus.mem_write   = (state_q == StWrite);
    assign bus.mem_address = mem_address_q;
    assign bus.mem_data    = mem_data_q;

    assign busy         = (state_q == StCount) || (state_q == StData) ||
                          (state_q == StWrite) || (state_q == StCheck);
    assign core_hold    = busy;
    assign done         = done_q;
    assign error        = error_q;
    assign error_code   = error_code_q;
    assign words_loaded = words_q;

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        words_d       = words_q;
        byte_idx_d    = byte_idx_q;
        word_d        = word_q;
        csum_d        = csum_q;
        mem_address_d = mem_address_q;
        mem_data_d    = mem_data_q;
        done_d        = done_q;
        error_d       = error_q;
        error_code_d  = error_code_q;

        unique case (state_q)
            StIdle, StDone, StError: begin
                if (start) begin
                    state_d      = StCount;
                    done_d       = 1'b0;
                    error_d      = 1'b0;
                    error_code_d = 2'b00;
                    words_d      = '0;
                    csum_d       = '0;
                    byte_idx_d   = '0;
                end
            end
            StCount: begin
                if (accept) begin
                    csum_d  = csum_q ^ bus.in_data;
                    count_d = COUNT_W'(bus.in_data);
                    if ((bus.in_data == 8'd0) || (32'(bus.in_data) > DEPTH)) begin
                        state_d      = StError;
                        error_d      = 1'b1;
                        error_code_d = 2'b01;
                    end else begin
                        state_d    = StData;
                        byte_idx_d = '0;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    csum_d = csum_q ^ bus.in_data;
                    word_d[{byte_idx_q, 3'b000} +: 8] = bus.in_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        // Latch the write now so address/data hold after the strobe.
                        state_d       = StWrite;
                        mem_address_d = 32'({words_q, 2'b00});
                        mem_data_d    = word_d;
                    end
                end
            end
            StWrite: begin
                words_d = words_q + COUNT_W'(1);
                if ((words_q + COUNT_W'(1)) == count_q) begin
                    state_d = StCheck;
                end else begin
                    state_d = StData;
                end
            end
            StCheck: begin
                if (accept) begin
                    if (bus.in_data == csum_q) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        state_d      = StError;
                        error_d      = 1'b1;
                        error_code_d = 2'b10;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            count_q       <= '0;
            words_q       <= '0;
            byte_idx_q    <= '0;
            word_q        <= '0;
            csum_q        <= '0;
            mem_address_q <= '0;
            mem_data_q    <= '0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            error_code_q  <= 2'b00;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            words_q       <= words_d;
            byte_idx_q    <= byte_idx_d;
            word_q        <= word_d;
            csum_q        <= csum_d;
            mem_address_q <= mem_address_d;
            mem_data_q    <= mem_data_d;
            done_q        <= done_d;
            error_q       <= error_d;
            error_code_q  <= error_code_d;
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: normal, bad-count, bad-checksum, backpressure,
// mid-load reset and start-handling scenarios with hand-computed expectations.
module tb_instruction_loader;

    localparam int unsigned DEPTH   = 32;
    localparam int unsigned COUNT_W = 6;

    logic clock;
    logic reset;
    logic start;
    logic core_hold;
    logic busy;
    logic done;
    logic error;
    logic [1:0] error_code;
    logic [COUNT_W-1:0] words_loaded;

    instruction_loader_if bus ();

    instruction_loader #(
        .DEPTH   (DEPTH),
        .COUNT_W (COUNT_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .bus          (bus),
        .core_hold    (core_hold),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .error_code   (error_code),
        .words_loaded (words_loaded)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Write monitor: WRITE lasts one cycle, so exactly one negedge sees each strobe.
    int          wr_cnt = 0;
    logic [31:0] wr_addr [64];
    logic [31:0] wr_data [64];

    always @(negedge clock) begin
        if (bus.mem_write === 1'b1) begin
            wr_addr[wr_cnt % 64] = bus.mem_address;
            wr_data[wr_cnt % 64] = bus.mem_data;
            wr_cnt = wr_cnt + 1;
        end
    end

    logic [7:0] img [10];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"},  32'(bus.in_ready),    32'd0);
        check({tag, "_mem_write"}, 32'(bus.mem_write),   32'd0);
        check({tag, "_mem_addr"},  bus.mem_address,      32'd0);
        check({tag, "_mem_data"},  bus.mem_data,         32'd0);
        check({tag, "_core_hold"}, 32'(core_hold),       32'd0);
        check({tag, "_busy"},      32'(busy),            32'd0);
        check({tag, "_done"},      32'(done),            32'd0);
        check({tag, "_error"},     32'(error),           32'd0);
        check({tag, "_err_code"},  32'(error_code),      32'd0);
        check({tag, "_words"},     32'(words_loaded),    32'd0);
    endtask

    // Called at a negedge; returns at the negedge after the byte is accepted.
    task automatic send(input logic [7:0] b, input int gap);
        int tmo;
        repeat (gap) @(negedge clock);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        tmo = 0;
        while (bus.in_ready !== 1'b1 && tmo < 50) begin
            @(negedge clock);
            tmo++;
        end
        check("ready_timeout", 32'(tmo < 50), 32'd1);
        @(negedge clock);
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic load_image(input logic [7:0] last, input int gap);
        for (int i = 0; i < 9; i++) send(img[i], gap);
        send(last, gap);
    endtask

    task automatic check_std_writes(input string tag, input int base);
        check({tag, "_nwrites"}, 32'(wr_cnt - base),     32'd2);
        check({tag, "_addr0"},   wr_addr[base % 64],     32'h0000_0000);
        check({tag, "_data0"},   wr_data[base % 64],     32'h0050_0093);
        check({tag, "_addr1"},   wr_addr[(base + 1) % 64], 32'h0000_0004);
        check({tag, "_data1"},   wr_data[(base + 1) % 64], 32'h00A0_0113);
    endtask

    initial begin
        int base;
        img[0] = 8'h02;
        img[1] = 8'h93; img[2] = 8'h00; img[3] = 8'h50; img[4] = 8'h00;
        img[5] = 8'h13; img[6] = 8'h01; img[7] = 8'hA0; img[8] = 8'h00;
        img[9] = 8'h73;

        reset        = 1'b1;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (2) @(negedge clock);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clock);

        // Normal 2-word load
        base = wr_cnt;
        pulse_start();
        check("norm_busy",      32'(busy),         32'd1);
        check("norm_core_hold", 32'(core_hold),    32'd1);
        check("norm_in_ready",  32'(bus.in_ready), 32'd1);
        load_image(8'h73, 0);
        check_std_writes("norm", base);
        check("norm_done",      32'(done),         32'd1);
        check("norm_error",     32'(error),        32'd0);
        check("norm_words",     32'(words_loaded), 32'd2);
        check("norm_core_fall", 32'(core_hold),    32'd0);
        check("norm_busy_fall", 32'(busy),         32'd0);
        check("norm_ready_low", 32'(bus.in_ready), 32'd0);

        // Start after DONE, then bad count 33
        base = wr_cnt;
        pulse_start();
        check("restart_done",  32'(done),         32'd0);
        check("restart_words", 32'(words_loaded), 32'd0);
        check("restart_busy",  32'(busy),         32'd1);
        send(8'h21, 0);
        check("cnt33_error",    32'(error),        32'd1);
        check("cnt33_code",     32'(error_code),   32'd1);
        check("cnt33_ready",    32'(bus.in_ready), 32'd0);
        check("cnt33_done",     32'(done),         32'd0);
        check("cnt33_busy",     32'(busy),         32'd0);
        @(negedge clock);
        check("cnt33_nwrites",  32'(wr_cnt - base), 32'd0);

        // Bad count 0
        base = wr_cnt;
        pulse_start();
        check("cnt0_err_clr", 32'(error), 32'd0);
        send(8'h00, 0);
        check("cnt0_error",   32'(error),        32'd1);
        check("cnt0_code",    32'(error_code),   32'd1);
        check("cnt0_ready",   32'(bus.in_ready), 32'd0);
        @(negedge clock);
        check("cnt0_nwrites", 32'(wr_cnt - base), 32'd0);

        // Checksum mismatch
        base = wr_cnt;
        pulse_start();
        load_image(8'h74, 0);
        check_std_writes("csum", base);
        check("csum_error", 32'(error),        32'd1);
        check("csum_code",  32'(error_code),   32'd2);
        check("csum_done",  32'(done),         32'd0);
        check("csum_words", 32'(words_loaded), 32'd2);

        // Backpressure (3 idle cycles per byte) with an ignored start during DATA
        base = wr_cnt;
        pulse_start();
        send(img[0], 3);
        send(img[1], 3);
        send(img[2], 3);
        pulse_start();
        check("ign_start_busy",  32'(busy),         32'd1);
        check("ign_start_ready", 32'(bus.in_ready), 32'd1);
        for (int i = 3; i < 10; i++) send(img[i], 3);
        repeat (2) @(negedge clock);
        check_std_writes("bp", base);
        check("bp_done",  32'(done),         32'd1);
        check("bp_error", 32'(error),        32'd0);
        check("bp_words", 32'(words_loaded), 32'd2);

        // Reset after the 2nd data byte
        base = wr_cnt;
        pulse_start();
        send(img[0], 0);
        send(img[1], 0);
        send(img[2], 0);
        reset = 1'b1;
        #1;
        check_all_zero("midrst");
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("midrst_idle_busy", 32'(busy), 32'd0);
        check("midrst_nwrites",   32'(wr_cnt - base), 32'd0);

        base = wr_cnt;
        pulse_start();
        load_image(8'h73, 0);
        check_std_writes("post", base);
        check("post_done",  32'(done),         32'd1);
        check("post_words", 32'(words_loaded), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
